inv_permute_unit: RTL and testbench
===================================

INV_PERMUTE_UNIT -- requirements
Module: inv_permute_unit

Interface
REQ-001 Parameters SHALL be: SLICE_W, default 25, bits per state slice; SLICES, default 64, slices per state.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  one-cycle request to begin a 64-slice frame; honoured only in IDLE.
REQ-005 in_slice  input  SLICE_W  incoming slice; lane index i = x+5y.
REQ-006 in_valid / in_ready  input / output  1 each  input handshake; transfer occurs when both are high.
REQ-007 out_slice  output  SLICE_W  inverse-permuted slice.
REQ-008 out_valid / out_ready  output / input  1 each  output handshake; transfer occurs when both are high.
REQ-009 busy  output  1  high in RUN and DRAIN.
REQ-010 done  output  1  one-cycle pulse after the 64th slice leaves.
REQ-011 slice_cnt  output  7  number of slices accepted in the current frame, 0..64.

Function
REQ-012 The mapping SHALL be the inverse pi step: out bit (x+5y) = in bit (y + 5*((2x+3y) mod 5)), for x,y in 0..4; combinational, no further logic.
REQ-013 The FSM SHALL have states IDLE, RUN, DRAIN, DONE.
REQ-014 IDLE->RUN SHALL occur on start; slice_cnt SHALL clear to 0 on the same edge.
REQ-015 in_ready SHALL equal (state==RUN) && (!out_valid || out_ready).
REQ-016 On each input transfer, the permuted slice SHALL load into the output register on the next edge, out_valid SHALL be set, and slice_cnt SHALL increment; latency 1 cycle.
REQ-017 out_valid SHALL stay high and out_slice stable until an output transfer; without a concurrent load, out_valid SHALL then clear.
REQ-018 A simultaneous output transfer and input transfer SHALL replace the register contents with no bubble, sustaining 1 slice/cycle.
REQ-019 RUN->DRAIN SHALL occur on the edge that accepts the 64th slice (slice_cnt reaches 64); in_ready SHALL be low in DRAIN.
REQ-020 DRAIN->DONE SHALL occur on the output transfer of the last slice; DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-021 start outside IDLE SHALL be ignored; in_valid outside RUN SHALL be ignored and SHALL NOT change slice_cnt.
REQ-022 slice_cnt SHALL never wrap past 64; it SHALL hold 64 through DRAIN/DONE/IDLE until the next start.

Reset
REQ-023 rst SHALL force, on the next edge, state=IDLE, out_valid=0, out_slice=0, slice_cnt=0, done=0, busy=0, in_ready=0.
REQ-024 rst mid-frame SHALL discard the buffered slice without producing done; rst SHALL dominate start and both handshakes.

Configuration
REQ-025 With INV_PERMUTE_PARITY_EN defined, an output out_parity (1 bit) SHALL carry the XOR of the registered out_slice, valid alongside out_valid, reset to 0.
REQ-026 Without INV_PERMUTE_PARITY_EN, out_parity SHALL be absent and the logic SHALL be unchanged otherwise.

Structure
REQ-027 A shared package SHALL hold SLICE_W, SLICES, the lane-count constant 5, the FSM state typedef, and the inverse-pi index function.
REQ-028 The combinational mapping SHALL be a sub-module inv_pi_slice (SLICE_W in, SLICE_W out); the FSM, counter and output register SHALL live in the top module.

Verification
REQ-029 Drive in_slice one-hot bit 10 -> out_slice one-hot bit 1; in bit 16 -> out bit 5; in bit 0 -> out bit 0.
REQ-030 Drive start, 64 back-to-back slices with out_ready=1 -> 64 outputs on consecutive cycles, slice_cnt=64, done pulses once, 1 cycle after the last output.
REQ-031 Hold out_ready=0 for 5 cycles mid-frame -> in_ready=0, out_slice stable, no slice lost or duplicated.
REQ-032 Apply rst after 20 slices -> next cycle out_valid=0, slice_cnt=0, state IDLE, no done.
REQ-033 Pulse start during RUN; drive in_valid in IDLE -> no effect on slice_cnt or outputs.
REQ-034 Model check: a random 64-slice frame, forward pi applied after this block -> input frame reproduced bit-exact; with INV_PERMUTE_PARITY_EN, out_parity matches the XOR of each slice.

Source files
------------

// File: rtl/inv_permute_unit_pkg.sv
// rtl/inv_permute_unit_pkg.sv - shared constants, FSM state type and inverse-pi index function
package inv_permute_unit_pkg;

  localparam int SLICE_W = 25;
  localparam int SLICES  = 64;
  localparam int LANES   = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Input lane that lands on output lane i = x+5y under the inverse pi step.
  function automatic int inv_pi_src(input int i);
    int x;
    int y;
    x = i % LANES;
    y = i / LANES;
    return y + LANES * ((2 * x + 3 * y) % LANES);
  endfunction

endpackage

// File: rtl/inv_pi_slice.sv
// rtl/inv_pi_slice.sv - combinational inverse-pi lane shuffle of one slice
module inv_pi_slice
  import inv_permute_unit_pkg::*;
#(
  parameter int SLICE_W = inv_permute_unit_pkg::SLICE_W
) (
  input  logic [SLICE_W-1:0] in_slice,
  output logic [SLICE_W-1:0] out_slice
);

  localparam int LANE_BITS = LANES * LANES;

  // Bits above the 5x5 lane grid are carried straight through.
  for (genvar i = 0; i < SLICE_W; i++) begin : g_bit
    if (i < LANE_BITS) begin : g_pi
      localparam int SRC = inv_pi_src(i);
      assign out_slice[i] = in_slice[SRC];
    end else begin : g_pass
      assign out_slice[i] = in_slice[i];
    end
  end

endmodule

// File: rtl/inv_permute_unit.sv
// rtl/inv_permute_unit.sv - framed inverse-pi slice stream; INV_PERMUTE_PARITY_EN adds out_parity
module inv_permute_unit
  import inv_permute_unit_pkg::*;
#(
  parameter int SLICE_W = inv_permute_unit_pkg::SLICE_W,
  parameter int SLICES  = inv_permute_unit_pkg::SLICES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SLICE_W-1:0] in_slice,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [SLICE_W-1:0] out_slice,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done,
`ifdef INV_PERMUTE_PARITY_EN
  output logic               out_parity,
`endif
  output logic [6:0]         slice_cnt
);

  localparam logic [6:0] LAST_CNT = 7'(SLICES - 1);

  state_t             state;
  state_t             state_nxt;
  logic [SLICE_W-1:0] perm_slice;
  logic               in_xfer;
  logic               out_xfer;
  logic               last_in;

  inv_pi_slice #(.SLICE_W(SLICE_W)) u_inv_pi (
    .in_slice  (in_slice),
    .out_slice (perm_slice)
  );

  assign in_ready = (state == ST_RUN) && (!out_valid || out_ready);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign last_in  = in_xfer && (slice_cnt == LAST_CNT);

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last_in) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (out_xfer) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      out_slice <= '0;
      slice_cnt <= 7'd0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && start) begin
        slice_cnt <= 7'd0;
      end else if (in_xfer) begin
        slice_cnt <= slice_cnt + 7'd1;
      end
      // A load during an output transfer simply overwrites, giving 1 slice/cycle.
      if (in_xfer) begin
        out_slice <= perm_slice;
        out_valid <= 1'b1;
      end else if (out_xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef INV_PERMUTE_PARITY_EN
  assign out_parity = ^out_slice;
`endif

endmodule

// File: tb/tb_inv_permute_unit.sv
// tb/tb_inv_permute_unit.sv - scoreboard bench checking outputs through the forward pi step
module tb_inv_permute_unit;

  localparam int W = 25;
  localparam int N = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] in_slice = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] out_slice;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         busy;
  logic         done;
  logic [6:0]   slice_cnt;
`ifdef INV_PERMUTE_PARITY_EN
  logic         out_parity;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic [W-1:0] exp_q[$];
  int out_cycles[$];

  inv_permute_unit #(.SLICE_W(W), .SLICES(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_slice  (in_slice),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_slice (out_slice),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
`ifdef INV_PERMUTE_PARITY_EN
    .out_parity(out_parity),
`endif
    .slice_cnt (slice_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Forward Keccak pi: lane (x,y) moves to lane (y, 2x+3y mod 5).
  function automatic logic [W-1:0] fwd_pi(input logic [W-1:0] a);
    logic [W-1:0] b;
    b = a;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        b[y + 5 * ((2 * x + 3 * y) % 5)] = a[x + 5 * y];
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  initial begin : monitor
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (out_valid && out_ready) begin
          out_cycles.push_back(cyc);
          if (exp_q.size() == 0) begin
            chk("unexpected_output", 32'(out_slice), 32'hdead);
          end else begin
            e = exp_q.pop_front();
            chk("slice_data", 32'(fwd_pi(out_slice)), 32'(e));
`ifdef INV_PERMUTE_PARITY_EN
            chk("parity", 32'(out_parity), 32'(^e));
`endif
          end
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input bit rnd);
    int n;
    n = 0;
    in_slice = d;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        chk("in_ready_timeout", 32'(n), 32'd0);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
    end
    exp_q.push_back(d);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (rnd) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done_cnt > d0) break;
    end
    repeat (3) @(negedge clk);
    chk("done_pulses", 32'(done_cnt - d0), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin : main
    int base;
    int d0;
    logic [W-1:0] hold;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_slice", 32'(out_slice), 32'd0);
    chk("rst_slice_cnt", 32'(slice_cnt), 32'd0);
    chk("rst_done_busy", {30'd0, done, busy}, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;

    // in_valid in IDLE must do nothing
    in_valid = 1'b1;
    in_slice = 25'h1abcdef;
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("idle_in_cnt", 32'(slice_cnt), 32'd0);
    chk("idle_in_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // Frame 1: directed one-hot, stall, start-in-RUN, then random backpressure
    base = out_cycles.size();
    d0 = done_cnt;
    pulse_start();
    @(negedge clk);
    chk("start_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    send(25'h1 << 10, 1'b0);
    @(negedge clk);
    chk("onehot10", 32'(out_slice), 32'h2);
    chk("cnt_after_1", 32'(slice_cnt), 32'd1);
    hold = out_slice;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_stable", 32'(out_slice), 32'(hold));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(25'h1 << 16, 1'b0);
    @(negedge clk);
    chk("onehot16", 32'(out_slice), 32'h20);
    @(posedge clk); #1;
    send(25'h1, 1'b0);
    @(negedge clk);
    chk("onehot0", 32'(out_slice), 32'h1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    pulse_start();
    @(negedge clk);
    chk("run_start_cnt", 32'(slice_cnt), 32'd3);
    chk("run_start_outv", 32'(out_valid), 32'd0);
    chk("run_start_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    for (int i = 3; i < N; i++) send(W'($urandom), 1'b1);
    out_ready = 1'b1;
    wait_done(d0);
    chk("f1_outputs", 32'(out_cycles.size() - base), 32'(N));
    chk("f1_done_lat", 32'(done_cyc - out_cycles[out_cycles.size() - 1]), 32'd1);
    chk("f1_cnt_hold", 32'(slice_cnt), 32'd64);
    chk("f1_idle_busy", 32'(busy), 32'd0);

    // Frame 2: back-to-back at full rate
    base = out_cycles.size();
    d0 = done_cnt;
    pulse_start();
    for (int i = 0; i < N; i++) send(W'($urandom), 1'b0);
    @(negedge clk);
    chk("drain_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    wait_done(d0);
    chk("f2_outputs", 32'(out_cycles.size() - base), 32'(N));
    if (out_cycles.size() - base == N)
      chk("f2_consecutive", 32'(out_cycles[base + N - 1] - out_cycles[base]), 32'(N - 1));
    chk("f2_done_lat", 32'(done_cyc - out_cycles[out_cycles.size() - 1]), 32'd1);
    chk("f2_cnt", 32'(slice_cnt), 32'd64);

    // Frame 3: reset after 20 slices, with a handshake pending
    d0 = done_cnt;
    pulse_start();
    for (int i = 0; i < 20; i++) send(W'($urandom), 1'b0);
    rst = 1'b1;
    in_valid = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    start = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_cnt", 32'(slice_cnt), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    repeat (5) @(negedge clk);
    chk("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
